// File: rtl/greenhouse_pkg.sv
// rtl/greenhouse_pkg.sv - shared greenhouse constants: status codes, converter FSM states, temperature limit
package greenhouse_pkg;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_COLD  = 2'b01,
        ST_HOT   = 2'b10,
        ST_FAULT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } fsm_state_t;

    localparam logic [8:0] MAX_TEMP_F = 9'd399;

    // Index of the last of the nine double-dabble shift steps
    localparam logic [3:0] SHIFT_LAST = 4'd8;

    // Clamp a raw reading to the displayable range
    function automatic logic [8:0] saturate_f(input logic [8:0] f);
        return (f > MAX_TEMP_F) ? MAX_TEMP_F : f;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/temp_bcd_converter.sv
// rtl/temp_bcd_converter.sv - sequential binary-to-BCD temperature converter with hysteretic status
module temp_bcd_converter
    import greenhouse_pkg::*;
#(
    parameter int HYST = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       SAMPLE_VALID,
    input  logic [8:0] SAMPLE_F,
    input  logic [8:0] SET_F,
    output logic       SAMPLE_READY,
    output logic [9:0] TEMP_F,
    output logic [1:0] STATUS,
    output logic       TEMP_UPDATE
);

    localparam logic [9:0] HYST_W = 10'(HYST);

    fsm_state_t  state;
    logic [3:0]  shift_cnt;
    logic [8:0]  bin_sr;
    logic [11:0] bcd_sr;
    logic [11:0] bcd_adj;
    logic [9:0]  temp_q;
    logic [9:0]  set_q;
    logic        sat_q;
    logic        ready_q;
    logic [9:0]  temp_f_q;
    status_t     status_q;
    status_t     status_next;
    logic        update_q;
    logic        adj_msb_unused;

    // Hundreds never exceeds 3, so its corrected MSB is shifted out and discarded
    assign adj_msb_unused = bcd_adj[11];

    for (genvar i = 0; i < 3; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_sr[4*i +: 4]),
            .adjusted (bcd_adj[4*i +: 4])
        );
    end

    assign SAMPLE_READY = ready_q;
    assign TEMP_F       = temp_f_q;
    assign STATUS       = status_q;
    assign TEMP_UPDATE  = update_q;

    // Status decision: hard thresholds first, then hold the previous HOT/COLD inside the band
    always_comb begin
        status_next = ST_OK;
        if (sat_q)
            status_next = ST_FAULT;
        else if (temp_q >= set_q + HYST_W)
            status_next = ST_HOT;
        else if (temp_q + HYST_W <= set_q)
            status_next = ST_COLD;
        else if (status_q == ST_HOT && temp_q > set_q)
            status_next = ST_HOT;
        else if (status_q == ST_COLD && temp_q < set_q)
            status_next = ST_COLD;
    end

    // Conversion FSM: capture, nine add-3-then-shift steps, then publish result for one cycle
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            shift_cnt <= 4'd0;
            bin_sr    <= 9'd0;
            bcd_sr    <= 12'd0;
            temp_q    <= 10'd0;
            set_q     <= 10'd0;
            sat_q     <= 1'b0;
            temp_f_q  <= 10'd0;
            status_q  <= ST_FAULT;
            update_q  <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (SAMPLE_VALID && ready_q) begin
                        state     <= S_SHIFT;
                        ready_q   <= 1'b0;
                        bin_sr    <= saturate_f(SAMPLE_F);
                        temp_q    <= {1'b0, saturate_f(SAMPLE_F)};
                        set_q     <= {1'b0, SET_F};
                        sat_q     <= (SAMPLE_F > MAX_TEMP_F);
                        bcd_sr    <= 12'd0;
                        shift_cnt <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    bcd_sr <= {bcd_adj[10:0], bin_sr[8]};
                    bin_sr <= {bin_sr[7:0], 1'b0};
                    if (shift_cnt == SHIFT_LAST) begin
                        state     <= S_DONE;
                        shift_cnt <= 4'd0;
                    end else begin
                        shift_cnt <= shift_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    ready_q  <= 1'b1;
                    temp_f_q <= bcd_sr[9:0];
                    status_q <= status_next;
                    update_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter.sv
// tb/tb_temp_bcd_converter.sv - self-checking bench for temp_bcd_converter
module tb_temp_bcd_converter;

    localparam int HYST = 2;

    logic       CLOCK_50     = 1'b0;
    logic       RESET_N      = 1'b0;
    logic       SAMPLE_VALID = 1'b0;
    logic [8:0] SAMPLE_F     = 9'd0;
    logic [8:0] SET_F        = 9'd0;
    logic       SAMPLE_READY;
    logic [9:0] TEMP_F;
    logic [1:0] STATUS;
    logic       TEMP_UPDATE;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    temp_bcd_converter #(.HYST(HYST)) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_F     (SAMPLE_F),
        .SET_F        (SET_F),
        .SAMPLE_READY (SAMPLE_READY),
        .TEMP_F       (TEMP_F),
        .STATUS       (STATUS),
        .TEMP_UPDATE  (TEMP_UPDATE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] to_bcd(input int v);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return 10'((h << 8) | (t << 4) | o);
    endfunction

    function automatic logic [1:0] model_status(input int t, input int s, input bit sat,
                                                input logic [1:0] prev);
        if (sat) return 2'b11;
        if (t >= s + HYST) return 2'b10;
        if (t + HYST <= s) return 2'b01;
        if (prev == 2'b10 && t > s) return 2'b10;
        if (prev == 2'b01 && t < s) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: a conversion is a 10-edge busy window followed by a published result
    bit         m_busy   = 1'b0;
    int         m_left   = 0;
    int         m_t      = 0;
    int         m_s      = 0;
    bit         m_sat    = 1'b0;
    logic [9:0] m_temp   = 10'd0;
    logic [1:0] m_status = 2'b11;
    bit         m_upd    = 1'b0;

    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            m_busy   = 1'b0;
            m_left   = 0;
            m_temp   = 10'd0;
            m_status = 2'b11;
            m_upd    = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_temp   = to_bcd(m_t);
                    m_status = model_status(m_t, m_s, m_sat, m_status);
                    m_upd    = 1'b1;
                end
            end else if (SAMPLE_VALID) begin
                m_busy = 1'b1;
                m_left = 10;
                m_sat  = (int'(SAMPLE_F) > 399);
                m_t    = m_sat ? 399 : int'(SAMPLE_F);
                m_s    = int'(SET_F);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLOCK_50) begin
        if (checking) begin
            chk("model_ready",  int'(SAMPLE_READY), int'(!m_busy));
            chk("model_temp",   int'(TEMP_F),       int'(m_temp));
            chk("model_status", int'(STATUS),       int'(m_status));
            chk("model_update", int'(TEMP_UPDATE),  int'(m_upd));
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_upd(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!TEMP_UPDATE && n < 30);
    endtask

    task automatic convert(input int sample, input int set, input int exp_temp,
                           input int exp_status, input string name);
        int n;
        SAMPLE_F     = 9'(sample);
        SET_F        = 9'(set);
        SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        wait_upd(n);
        chk({name, "_latency"}, n, 10);
        chk({name, "_temp"},    int'(TEMP_F), exp_temp);
        chk({name, "_status"},  int'(STATUS), exp_status);
        tick();
    endtask

    initial begin
        int n;
        int extra;
        int set_v;
        int smp;

        RESET_N = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        chk("reset_temp",   int'(TEMP_F),       0);
        chk("reset_status", int'(STATUS),       3);
        chk("reset_ready",  int'(SAMPLE_READY), 1);
        chk("reset_update", int'(TEMP_UPDATE),  0);
        RESET_N = 1'b1;
        tick();

        convert(72, 70, 'h072, 2, "t72");
        chk("t72_pulse_one_cycle", int'(TEMP_UPDATE), 0);

        convert(399, 70, 'h399, 2, "t399");
        convert(450, 70, 'h399, 3, "t450");
        convert(70,  70, 'h070, 0, "from_fault");

        convert(72, 70, 'h072, 2, "hy72");
        convert(71, 70, 'h071, 2, "hy71");
        convert(70, 70, 'h070, 0, "hy70");
        convert(68, 70, 'h068, 1, "hy68");
        convert(69, 70, 'h069, 1, "hy69");
        convert(70, 70, 'h070, 0, "hy70b");

        SAMPLE_F = 9'd72; SET_F = 9'd70; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        tick();
        tick();
        SAMPLE_F = 9'd55; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        n = 3;
        while (!TEMP_UPDATE && n < 30) begin
            tick();
            n++;
        end
        chk("drop_latency", n, 10);
        chk("drop_temp", int'(TEMP_F), 'h072);
        extra = 0;
        repeat (15) begin
            tick();
            if (TEMP_UPDATE) extra++;
        end
        chk("drop_no_second_update", extra, 0);

        SAMPLE_F = 9'd123; SET_F = 9'd70; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        repeat (4) tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        chk("abort_update", int'(TEMP_UPDATE),  0);
        chk("abort_temp",   int'(TEMP_F),       0);
        chk("abort_status", int'(STATUS),       3);
        chk("abort_ready",  int'(SAMPLE_READY), 1);
        extra = 0;
        repeat (15) begin
            tick();
            if (TEMP_UPDATE) extra++;
        end
        chk("abort_no_update", extra, 0);

        SAMPLE_F = 9'd0; SET_F = 9'd70; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_F = 9'd9;
        wait_upd(n);
        chk("stream0_latency", n, 10);
        chk("stream0_temp", int'(TEMP_F), 'h000);
        wait_upd(n);
        SAMPLE_VALID = 1'b0;
        chk("stream9_period", n, 11);
        chk("stream9_temp", int'(TEMP_F), 'h009);
        repeat (12) tick();

        set_v = 70;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) set_v = int'($urandom_range(20, 480));
            if ($urandom_range(0, 9) < 7)
                smp = set_v + int'($urandom_range(0, 8)) - 4;
            else
                smp = int'($urandom_range(0, 511));
            RESET_N      = ($urandom_range(0, 99) != 0);
            SAMPLE_VALID = ($urandom_range(0, 2) != 0);
            SAMPLE_F     = 9'(smp);
            SET_F        = 9'(set_v);
            tick();
        end
        RESET_N = 1'b1;
        SAMPLE_VALID = 1'b0;
        repeat (15) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_bcd_converter.md
TEMP_BCD_CONVERTER -- requirements
Module: temp_bcd_converter

Interface
REQ-001 SHALL have parameter HYST, default 2, hysteresis band in degrees F for status decisions.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port RESET_N  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port SAMPLE_VALID  input  1  new binary sample offered this cycle.
REQ-005 SHALL have port SAMPLE_F  input  9  binary temperature, degrees F, unsigned.
REQ-006 SHALL have port SET_F  input  9  binary setpoint, degrees F, unsigned.
REQ-007 SHALL have port SAMPLE_READY  output  1  high when the block accepts a sample.
REQ-008 SHALL have port TEMP_F  output  10  BCD result {hundreds[1:0], tens[3:0], ones[3:0]}, feeds display_controller TEMP_F.
REQ-009 SHALL have port STATUS  output  2  00 OK, 01 COLD, 10 HOT, 11 FAULT/no data.
REQ-010 SHALL have port TEMP_UPDATE  output  1  one-cycle pulse when TEMP_F/STATUS change.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; SAMPLE_READY = (state == IDLE).
REQ-012 SHALL accept a sample on an edge where SAMPLE_VALID && SAMPLE_READY, capturing SAMPLE_F and SET_F and moving to SHIFT.
REQ-013 SHALL saturate captured sample to 399 when SAMPLE_F > 399 and set an internal saturation flag.
REQ-014 SHALL perform sequential double-dabble in SHIFT: per edge, add 3 to every BCD nibble >= 5, then shift one binary bit in, MSB first; exactly 9 SHIFT edges, counted by a 4-bit counter 0..8.
REQ-015 SHALL move SHIFT -> DONE after the 9th shift, and DONE -> IDLE on the next edge, registering TEMP_F and STATUS on that edge.
REQ-016 SHALL give latency: sample accepted at edge N, TEMP_F/STATUS/TEMP_UPDATE valid after edge N+10; SAMPLE_READY low after edges N..N+9, high again after edge N+10.
REQ-017 SHALL assert TEMP_UPDATE for exactly one cycle per completed conversion; TEMP_F/STATUS hold between updates.
REQ-018 SHALL ignore (drop, no queue) SAMPLE_VALID while SAMPLE_READY is low.
REQ-019 SHALL sustain one conversion per 11 cycles when SAMPLE_VALID is held high.
REQ-020 SHALL compute STATUS from the saturated sample T and captured setpoint S, using 10-bit unsigned arithmetic (no overflow):
 - saturation flag set -> FAULT;
 - T >= S+HYST -> HOT; T+HYST <= S -> COLD;
 - else if previous STATUS is HOT and T > S -> HOT (hold);
 - else if previous STATUS is COLD and T < S -> COLD (hold);
 - else OK.
REQ-021 SHALL produce STATUS from FAULT by the non-hold rules only.

Reset
REQ-022 SHALL, while RESET_N is low at an edge, set state IDLE, counter 0, TEMP_F 0, STATUS 11, TEMP_UPDATE 0, scratch registers 0.
REQ-023 SHALL abort a conversion in progress on reset with no TEMP_UPDATE pulse; SAMPLE_READY is 1 in the first cycle after reset.
REQ-024 SHALL ignore SAMPLE_VALID on any edge where RESET_N is low.

Structure
REQ-025 SHALL take STATUS codes, FSM state encodings and MAX_TEMP_F = 399 from the shared greenhouse constants package, also used by temp_status_block.
REQ-026 SHALL use one sub-module bcd_digit_adj (4-bit nibble: +3 if >= 5), instantiated once per BCD nibble.

Verification
REQ-027 SHALL cover: reset, SET_F=70, SAMPLE_F=72 valid at edge N -> after edge N+10 TEMP_F=0x072, STATUS=10, one TEMP_UPDATE pulse.
REQ-028 SHALL cover: SAMPLE_F=399 -> TEMP_F=0x399, STATUS per setpoint; SAMPLE_F=450 -> TEMP_F=0x399, STATUS=11.
REQ-029 SHALL cover hysteresis with SET_F=70, HYST=2, sample sequence 72,71,70,68,69,70 -> STATUS sequence 10,10,00,01,01,00.
REQ-030 SHALL cover: SAMPLE_F=55 offered 3 cycles after accepting 72 -> dropped; single update, TEMP_F=0x072.
REQ-031 SHALL cover: RESET_N low at 5th SHIFT edge -> no TEMP_UPDATE, TEMP_F=0, STATUS=11, SAMPLE_READY=1 next cycle.
REQ-032 SHALL cover: SAMPLE_VALID held high with SAMPLE_F=0 then 9 -> TEMP_UPDATE every 11 cycles, TEMP_F=0x000 then 0x009.
